// File: rtl/snic_req_arbiter_if.sv
// Handshake bundle between the local requesters, snic_req_arbiter and the slave NIC.
interface snic_req_arbiter_if #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned PAYLOAD_WIDTH = 32,
    parameter int unsigned XY_WIDTH      = 4
);
    localparam int unsigned SRC_W = 2 * XY_WIDTH;

    logic [NREQ-1:0]               req_valid;
    logic [NREQ*PAYLOAD_WIDTH-1:0] req_payload;
    logic [NREQ*SRC_W-1:0]         req_src;
    logic [NREQ-1:0]               req_ready;
    logic                          nic_valid;
    logic [PAYLOAD_WIDTH-1:0]      nic_payload;
    logic [SRC_W-1:0]              nic_src;
    logic                          nic_busy;
    logic                          nic_done;

    // Arbiter side
    modport slave (
        input  req_valid, req_payload, req_src, nic_busy, nic_done,
        output req_ready, nic_valid, nic_payload, nic_src
    );

    // Requester / NIC side
    modport master (
        output req_valid, req_payload, req_src, nic_busy, nic_done,
        input  req_ready, nic_valid, nic_payload, nic_src
    );
endinterface

// File: rtl/snic_req_arbiter.sv
// Round-robin scheduler forwarding one local request at a time to the slave NIC.
// Optional WAIT_DONE watchdog (abort / err_cnt) enabled by defining SNIC_ARB_TIMEOUT_EN.
module snic_req_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned GW             = 2,
    parameter int unsigned PAYLOAD_WIDTH  = 32,
    parameter int unsigned XY_WIDTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    snic_req_arbiter_if.slave bus,
    output logic [GW-1:0]     grant_id,
    output logic              abort,
    output logic [7:0]        err_cnt
);
    localparam int unsigned SRC_W = 2 * XY_WIDTH;

    if (NREQ < 2 || NREQ > 8 || NREQ > (1 << GW) ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_cfg_check
        $error("snic_req_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [GW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
    logic [SRC_W-1:0]         src_q, src_d;
    logic [NREQ-1:0]          ready_q, ready_d;

    logic                     found;
    logic [GW-1:0]            sel_id;
    logic [NREQ-1:0]          sel_oh;
    logic [PAYLOAD_WIDTH-1:0] sel_payload;
    logic [SRC_W-1:0]         sel_src;
    logic                     nic_valid_c;

`ifdef SNIC_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        abort_q, abort_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
`endif

    // Nearest valid requester after rr_ptr; smaller distances are visited last and win.
    always_comb begin
        found       = 1'b0;
        sel_id      = '0;
        sel_oh      = '0;
        sel_payload = '0;
        sel_src     = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (bus.req_valid[i] && ((int'(rr_ptr_q) + k) % int'(NREQ)) == i) begin
                    found       = 1'b1;
                    sel_id      = GW'(i);
                    sel_oh      = '0;
                    sel_oh[i]   = 1'b1;
                    sel_payload = bus.req_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                    sel_src     = bus.req_src[i*SRC_W +: SRC_W];
                end
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        payload_d   = payload_q;
        src_d       = src_q;
        ready_d     = '0;
`ifdef SNIC_ARB_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
        abort_d     = 1'b0;
        err_cnt_d   = err_cnt_q;
`endif
        nic_valid_c = (state_q == S_ISSUE) && !bus.nic_busy;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d   = S_ISSUE;
                    grant_d   = sel_id;
                    payload_d = sel_payload;
                    src_d     = sel_src;
                    ready_d   = sel_oh;
                end
            end
            S_ISSUE: begin
                if (nic_valid_c) begin
                    state_d = S_WAIT_DONE;
`ifdef SNIC_ARB_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (bus.nic_done) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = grant_q;
                end
`ifdef SNIC_ARB_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d   = S_IDLE;
                    rr_ptr_d  = grant_q;
                    abort_d   = 1'b1;
                    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= GW'(NREQ - 1);
            grant_q   <= '0;
            payload_q <= '0;
            src_q     <= '0;
            ready_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            payload_q <= payload_d;
            src_q     <= src_d;
            ready_q   <= ready_d;
        end
    end

`ifdef SNIC_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q  <= '0;
            abort_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            abort_q   <= abort_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign abort   = abort_q;
    assign err_cnt = err_cnt_q;
`else
    assign abort   = 1'b0;
    assign err_cnt = '0;
`endif

    assign bus.req_ready   = ready_q;
    assign bus.nic_valid   = nic_valid_c;
    assign bus.nic_payload = payload_q;
    assign bus.nic_src     = src_q;
    assign grant_id        = grant_q;
endmodule

// File: tb/tb_snic_req_arbiter.sv
// Bench for snic_req_arbiter: directed vector table, hand-written corner sequences, random run vs reference model.
module tb_snic_req_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned GW   = 2;
    localparam int unsigned PW   = 32;
    localparam int unsigned XW   = 4;
    localparam int unsigned SW   = 2 * XW;
    localparam int unsigned TO   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snic_req_arbiter_if #(.NREQ(NREQ), .PAYLOAD_WIDTH(PW), .XY_WIDTH(XW)) bus ();

    logic [GW-1:0] grant_id;
    logic          abort;
    logic [7:0]    err_cnt;

    snic_req_arbiter #(
        .NREQ(NREQ), .GW(GW), .PAYLOAD_WIDTH(PW), .XY_WIDTH(XW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .grant_id(grant_id), .abort(abort), .err_cnt(err_cnt)
    );

    logic [NREQ-1:0] r_valid;
    logic [PW-1:0]   r_pay [NREQ];
    logic [SW-1:0]   r_src [NREQ];

    assign bus.req_valid   = r_valid;
    assign bus.req_payload = {r_pay[3], r_pay[2], r_pay[1], r_pay[0]};
    assign bus.req_src     = {r_src[3], r_src[2], r_src[1], r_src[0]};

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NREQ-1:0] valid;
        int              busy_n;
        int              done_dly;
        bit              spur;
        int              exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    // Round-robin rule: first valid requester scanning upward from rr+1, wrapping.
    function automatic int rr_pick(input int rr, input logic [NREQ-1:0] v);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int j;
            j = (rr + k) % int'(NREQ);
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        r_valid = '0;
        bus.nic_busy = 1'b0;
        bus.nic_done = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            r_pay[i] = '0;
            r_src[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},   64'(bus.req_ready),   64'(0));
        chk({tag, "_nic_valid"},   64'(bus.nic_valid),   64'(0));
        chk({tag, "_nic_payload"}, 64'(bus.nic_payload), 64'(0));
        chk({tag, "_nic_src"},     64'(bus.nic_src),     64'(0));
        chk({tag, "_grant_id"},    64'(grant_id),        64'(0));
        chk({tag, "_abort"},       64'(abort),           64'(0));
        chk({tag, "_err_cnt"},     64'(err_cnt),         64'(0));
    endtask

    // One full transaction from an IDLE cycle through the nic_done cycle.
    task automatic run_txn(input int k, input vec_t v);
        logic [PW-1:0] e_pay;
        logic [SW-1:0] e_src;
        step();
        for (int i = 0; i < int'(NREQ); i++) begin
            r_pay[i] = PW'(32'hA5 + (i << 8) + (k << 16));
            r_src[i] = SW'(i * 16 + k);
        end
        r_valid = v.valid;
        bus.nic_busy = 1'b0;
        bus.nic_done = v.spur;
        #1;
        chk("idle_req_ready", 64'(bus.req_ready), 64'(0));
        chk("idle_nic_valid", 64'(bus.nic_valid), 64'(0));
        e_pay = r_pay[v.exp];
        e_src = r_src[v.exp];
        step();
        bus.nic_busy = (v.busy_n > 0);
        bus.nic_done = v.spur;
        #1;
        chk("grant_req_ready", 64'(bus.req_ready),   64'(oh(v.exp)));
        chk("grant_id",        64'(grant_id),        64'(v.exp));
        chk("grant_payload",   64'(bus.nic_payload), 64'(e_pay));
        chk("grant_src",       64'(bus.nic_src),     64'(e_src));
        chk("grant_nic_valid", 64'(bus.nic_valid),   64'(v.busy_n == 0));
        for (int b = 1; b <= v.busy_n; b++) begin
            step();
            r_valid = '0;
            r_pay[v.exp] = ~e_pay;
            bus.nic_busy = (b < v.busy_n);
            bus.nic_done = v.spur;
            #1;
            chk("busy_req_ready", 64'(bus.req_ready),   64'(0));
            chk("busy_nic_valid", 64'(bus.nic_valid),   64'(b == v.busy_n));
            chk("busy_payload",   64'(bus.nic_payload), 64'(e_pay));
        end
        for (int d = 1; d <= v.done_dly; d++) begin
            step();
            r_valid = '0;
            r_pay[v.exp] = ~e_pay;
            bus.nic_busy = 1'b1;
            bus.nic_done = (d == v.done_dly);
            #1;
            chk("wait_req_ready", 64'(bus.req_ready),   64'(0));
            chk("wait_nic_valid", 64'(bus.nic_valid),   64'(0));
            chk("wait_payload",   64'(bus.nic_payload), 64'(e_pay));
            chk("wait_src",       64'(bus.nic_src),     64'(e_src));
        end
    endtask

    task automatic random_test(input int ncyc);
        int m_rr, m_g, g_cyc, done_at, free_at, ngrant;
        bit m_pend, m_acc, exp_nv;
        logic [NREQ-1:0] exp_ready;
        logic [PW-1:0] e_pay;
        logic [SW-1:0] e_src;
        m_rr = int'(NREQ) - 1;
        m_g = 0; g_cyc = -10; done_at = -10; free_at = 0; ngrant = 0;
        m_pend = 1'b0; m_acc = 1'b0;
        e_pay = '0; e_src = '0;
        for (int c = 0; c < ncyc; c++) begin
            step();
            for (int i = 0; i < int'(NREQ); i++) begin
                if (g_cyc == c - 1 && m_g == i) begin
                    r_valid[i] = ($urandom_range(3) == 0);
                    r_pay[i] = $urandom;
                    r_src[i] = SW'($urandom);
                end else if (!r_valid[i] && $urandom_range(3) == 0) begin
                    r_valid[i] = 1'b1;
                    r_pay[i] = $urandom;
                    r_src[i] = SW'($urandom);
                end
            end
            bus.nic_busy = ($urandom_range(2) == 0);
            bus.nic_done = m_acc ? (c == done_at) : ($urandom_range(7) == 0);
            exp_ready = (m_pend && c == g_cyc) ? oh(m_g) : '0;
            exp_nv = m_pend && !m_acc && c >= g_cyc && !bus.nic_busy;
            #1;
            chk("rnd_req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rnd_nic_valid", 64'(bus.nic_valid), 64'(exp_nv));
            chk("rnd_abort",     64'(abort),         64'(0));
            if (m_pend && c >= g_cyc) begin
                chk("rnd_grant_id", 64'(grant_id),        64'(m_g));
                chk("rnd_payload",  64'(bus.nic_payload), 64'(e_pay));
                chk("rnd_src",      64'(bus.nic_src),     64'(e_src));
            end
            if (m_pend && m_acc && c == done_at) begin
                m_pend = 1'b0;
                m_acc = 1'b0;
                m_rr = m_g;
                free_at = c + 1;
            end else if (exp_nv) begin
                m_acc = 1'b1;
                done_at = c + int'($urandom_range(6, 1));
            end
            if (!m_pend && c >= free_at && r_valid != '0) begin
                m_g = rr_pick(m_rr, r_valid);
                m_pend = 1'b1;
                g_cyc = c + 1;
                e_pay = r_pay[m_g];
                e_src = r_src[m_g];
                ngrant++;
            end
        end
        n_cmp++;
        if (ngrant < 50) begin
            n_bad++;
            $display("FAIL rnd_grant_count: got %0d, want >= 50", ngrant);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no $finish by %0t, want completion", $time);
        $fatal(1);
    end

    initial begin
        vec_t vt [12];
        int rdy_cyc [5];
        int rdy_idx [5];
        int nrdy, nv;
        int exp_order [5];

        vt[0]  = '{4'b0001, 0,  3, 1'b0, 0};
        vt[1]  = '{4'b1111, 10, 2, 1'b0, 1};
        vt[2]  = '{4'b1111, 0,  5, 1'b1, 2};
        vt[3]  = '{4'b1111, 2,  1, 1'b1, 3};
        vt[4]  = '{4'b1111, 0,  1, 1'b0, 0};
        vt[5]  = '{4'b0001, 1,  4, 1'b0, 0};
        vt[6]  = '{4'b1000, 0,  2, 1'b1, 3};
        vt[7]  = '{4'b0110, 3,  1, 1'b0, 1};
        vt[8]  = '{4'b0011, 0,  2, 1'b0, 0};
        vt[9]  = '{4'b1100, 0,  3, 1'b1, 2};
        vt[10] = '{4'b0100, 0,  1, 1'b0, 2};
        vt[11] = '{4'b0011, 1,  2, 1'b0, 0};
        exp_order = '{0, 1, 2, 3, 0};

        do_reset();
        chk_all_zero("reset");

        for (int k = 0; k < 12; k++) run_txn(k, vt[k]);

        // Back-to-back: all valid, nic_done 5 cycles after each nic_valid
        do_reset();
        nrdy = 0;
        nv = -100;
        for (int c = 0; c < 60 && nrdy < 5; c++) begin
            step();
            r_valid = 4'b1111;
            bus.nic_busy = 1'b0;
            bus.nic_done = (c == nv + 5);
            #1;
            if (bus.req_ready != '0) begin
                chk("b2b_onehot", 64'($countones(bus.req_ready)), 64'(1));
                for (int i = 0; i < int'(NREQ); i++)
                    if (bus.req_ready[i]) rdy_idx[nrdy] = i;
                rdy_cyc[nrdy] = c;
                nrdy++;
            end
            if (bus.nic_valid) nv = c;
        end
        chk("b2b_grant_count", 64'(nrdy), 64'(5));
        for (int g = 0; g < nrdy; g++) begin
            chk("b2b_order", 64'(rdy_idx[g]), 64'(exp_order[g]));
            if (g > 0) chk("b2b_gap", 64'(rdy_cyc[g] - rdy_cyc[g-1]), 64'(7));
        end

`ifdef SNIC_ARB_TIMEOUT_EN
        // Watchdog expiry, then nic_done coincident with expiry
        do_reset();
        step();
        r_valid = 4'b1111;
        #1;
        step();
        #1;
        chk("to_grant0", 64'(bus.req_ready), 64'(oh(0)));
        chk("to_accept0", 64'(bus.nic_valid), 64'(1));
        for (int w = 1; w <= int'(TO); w++) begin
            step();
            #1;
            chk("to_no_abort", 64'(abort), 64'(0));
        end
        step();
        #1;
        chk("to_abort", 64'(abort), 64'(1));
        chk("to_err_cnt", 64'(err_cnt), 64'(1));
        chk("to_idle_ready", 64'(bus.req_ready), 64'(0));
        step();
        #1;
        chk("to_abort_pulse", 64'(abort), 64'(0));
        chk("to_grant1", 64'(bus.req_ready), 64'(oh(1)));
        chk("to_accept1", 64'(bus.nic_valid), 64'(1));
        for (int w = 1; w <= int'(TO); w++) begin
            step();
            bus.nic_done = (w == int'(TO));
            #1;
            chk("to_coinc_no_abort", 64'(abort), 64'(0));
        end
        step();
        bus.nic_done = 1'b0;
        #1;
        chk("to_coinc_abort", 64'(abort), 64'(0));
        chk("to_coinc_err_cnt", 64'(err_cnt), 64'(1));
        step();
        #1;
        chk("to_grant2", 64'(bus.req_ready), 64'(oh(2)));
`else
        // Without the watchdog a missing nic_done simply stalls
        do_reset();
        step();
        r_valid = 4'b0001;
        #1;
        step();
        #1;
        chk("stall_grant0", 64'(bus.req_ready), 64'(oh(0)));
        for (int w = 1; w <= 40; w++) begin
            step();
            r_valid = 4'b1110;
            bus.nic_done = (w == 40);
            #1;
            chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
            chk("stall_abort", 64'(abort), 64'(0));
            chk("stall_err_cnt", 64'(err_cnt), 64'(0));
        end
        step();
        bus.nic_done = 1'b0;
        #1;
        step();
        #1;
        chk("stall_grant1", 64'(bus.req_ready), 64'(oh(1)));
`endif

        // Reset while requester 2 is in WAIT_DONE
        do_reset();
        step();
        r_valid = 4'b0100;
        r_pay[2] = 32'hDEAD_BEEF;
        r_src[2] = 8'h5A;
        #1;
        step();
        #1;
        chk("rstmid_grant2", 64'(bus.req_ready), 64'(oh(2)));
        step();
        r_valid = '0;
        #1;
        step();
        #1;
        chk("rstmid_grant_id", 64'(grant_id), 64'(2));
        chk("rstmid_payload", 64'(bus.nic_payload), 64'(32'hDEAD_BEEF));
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rstmid");
        r_valid = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        step();
        #1;
        chk("rstmid_after_grant", 64'(bus.req_ready), 64'(oh(0)));
        chk("rstmid_after_id", 64'(grant_id), 64'(0));

        do_reset();
        random_test(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/snic_req_arbiter.md
# snic_req_arbiter

Round-robin request scheduler in front of the slave-side NoC interface controller. Up to `NREQ` local requesters (depacketised NoC request streams, one per virtual source) compete for the single request port of the slave NIC. The arbiter forwards exactly one request at a time and holds the grant until the NIC reports transaction completion. Write requests are therefore never presented while a previous transaction is in flight.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `GW`, 2, grant index width, ≥ clog2(`NREQ`)
- `TIMEOUT_CYCLES`, 1024, watchdog limit in `WAIT_DONE` (only with `SNIC_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request pending per requester
- `req_payload`  in  NREQ*`PAYLOAD_WIDTH`  request flit payload, slice i = requester i
- `req_src`  in  NREQ*(`XY_WIDTH`*2)  source {y,x} per requester
- `req_ready`  out  NREQ  one-cycle accept pulse, one-hot
- `nic_valid`  out  1  request strobe to NIC
- `nic_payload`  out  `PAYLOAD_WIDTH`  latched payload of granted request
- `nic_src`  out  `XY_WIDTH`*2  latched source of granted request
- `nic_busy`  in  1  NIC is not in its IDLE state
- `nic_done`  in  1  one-cycle pulse at NIC read/write completion
- `grant_id`  out  GW  index of current/last grant
- `abort`  out  1  watchdog expiry pulse
- `err_cnt`  out  8  saturating count of watchdog expiries

## Operation
- States: `IDLE`, `ISSUE`, `WAIT_DONE`.
- `IDLE`:
  - If any `req_valid` is set, select the first set bit scanning from `rr_ptr+1` upward, wrapping at `NREQ-1` to 0.
  - Latch that requester's payload/src into `nic_payload`/`nic_src`, set `grant_id`, go to `ISSUE`.
- `ISSUE`:
  - `req_ready[grant_id]` = 1 on the first `ISSUE` cycle only.
  - `nic_valid` = (state==`ISSUE`) & !`nic_busy`. When it is high, go to `WAIT_DONE` at the next edge.
  - While `nic_busy`=1, stay in `ISSUE` with `nic_valid`=0.
- `WAIT_DONE`:
  - On `nic_done`, set `rr_ptr` ← `grant_id` and go to `IDLE`.
  - `nic_done` is ignored in `IDLE` and `ISSUE`.
- Requester contract: hold `req_valid`/payload stable until `req_ready`. Deassert valid in the cycle after `req_ready` unless a new request is ready. A drop before `req_ready` after capture does not cancel the request.
- `rr_ptr` is GW bits; reset value is `NREQ-1`, so requester 0 wins first.
- Reset (`rst`=0, asynchronous) values:
  - state `IDLE`; `req_ready`=0; `nic_valid`=0; `nic_payload`=0; `nic_src`=0; `grant_id`=0; `abort`=0; `err_cnt`=0; watchdog counter 0.
  - Reset mid-transaction discards the grant; no `nic_done` is awaited afterwards.

## Timing
- Grant latency: `req_valid` sampled at edge 0 → `req_ready` and `nic_valid` high in cycle 1 (NIC idle) → `WAIT_DONE` from edge 2.
- `nic_done` in cycle k → `IDLE` at edge k+1 → next `req_ready` earliest in cycle k+2. Back-to-back throughput is 1 request per (NIC latency + 2) cycles.
- `nic_payload`/`nic_src` are stable from the first `ISSUE` cycle until the next `IDLE` exit.
- `req_ready` and `abort` are registered single-cycle pulses. `nic_valid` is combinational from state and `nic_busy`.
- A new request arriving while another is served waits. The rotation guarantees each requester a grant within `NREQ` transactions.

## Configuration
- `SNIC_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to `WAIT_DONE` and increments every cycle there.
  - When it reaches `TIMEOUT_CYCLES-1` without `nic_done`: pulse `abort` for one cycle, `err_cnt` += 1 (saturating at 255), `rr_ptr` ← `grant_id`, go to `IDLE`.
  - `nic_done` in the same cycle as expiry wins: no abort, no increment.
- Not defined: no counter. `WAIT_DONE` waits indefinitely. `abort` and `err_cnt` are tied to 0.

## Test plan
- Reset, then `req_valid`=4'b0001 with payload 0xA5 → `req_ready`=4'b0001 and `nic_valid`=1 in cycle 1, `nic_payload`=0xA5, `grant_id`=0.
- All four requesters valid continuously, `nic_done` 5 cycles after each `nic_valid` → grant order 0,1,2,3,0, with exactly 7 cycles between `req_ready` pulses.
- `nic_busy`=1 for 10 cycles while in `ISSUE` → `nic_valid` stays 0, payload is held, `req_ready` pulses once. `nic_valid`=1 the cycle `nic_busy` falls.
- `nic_done` pulsed while in `IDLE` and in `ISSUE` → no state change; the transaction still completes on the later `nic_done`.
- With `SNIC_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no `nic_done` → `abort` pulses 16 cycles after entering `WAIT_DONE`, `err_cnt`=1, next requester granted. Repeat with `nic_done` coincident with expiry → no abort.
- Assert `rst`=0 during `WAIT_DONE` with requester 2 granted → all outputs 0 immediately. After release with all valid, requester 0 is granted first.
